// File: rtl/serial_add_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_sub_pkg
// Shared definitions for the bit-serial add/subtract unit:
//   - state_t   : controller states IDLE / RUN / DONE
//   - N_DEF     : default operand width
//   - cnt_width : width of the bit counter for an N-bit operation
// -----------------------------------------------------------------------------
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_DEF = 4;

    // Counter only has to reach N-1, so $clog2(N) bits suffice.
    // Clamp to one bit so a degenerate width never yields a zero-width vector.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_bit_cell.sv
// -----------------------------------------------------------------------------
// serial_bit_cell
// Combinational full-adder bit used by the serial datapath. The carry is
// registered by the parent, not here.
//   a, b, cin : operand bits and carry in
//   s         : sum bit
//   cout      : carry out
// -----------------------------------------------------------------------------
module serial_bit_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | ((a ^ b) & cin);

endmodule

// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
// Bit-serial signed add/subtract: R = X + Y (sub=0) or R = X - Y (sub=1),
// one bit per clock, LSB first, through one full-adder cell.
//
// Handshake: start is accepted only on a cycle where ready=1 (IDLE). The
// operands and sub are captured on that edge. done is a one-cycle pulse in
// which R, cout and ovf are final; they are held until the next accepted start.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start, sub : request and operation select (sampled with start)
//   X, Y       : N-bit two's complement operands
//   ready      : high in IDLE
//   busy       : high in RUN (exactly N cycles per operation)
//   done       : one-cycle result-valid pulse
//   R          : result (partial shifts visible during RUN)
//   cout       : carry out of MSB (subtract: 1 = no borrow)
//   ovf        : signed overflow (carry into MSB xor carry out of MSB)
// -----------------------------------------------------------------------------
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] R,
    output logic         cout,
    output logic         ovf
);

    localparam int            CW      = cnt_width(N);
    localparam logic [CW-1:0] LAST    = CW'(N - 1);
    localparam logic [CW-1:0] MSB_IN  = CW'(N - 2);

    state_t         state, state_nxt;
    logic [N-1:0]   a_sr, b_sr;
    logic           c_reg;
    logic           cmsb_in;
    logic [CW-1:0]  cnt;
    logic           bit_s, bit_c;

    serial_bit_cell u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (c_reg),
        .s    (bit_s),
        .cout (bit_c)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)       state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:                     state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    assign ready = (state == IDLE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            c_reg   <= 1'b0;
            cmsb_in <= 1'b0;
            cnt     <= '0;
            R       <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtract is X + ~Y + 1: invert B and seed the carry with 1.
                        a_sr  <= X;
                        b_sr  <= sub ? ~Y : Y;
                        c_reg <= sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    R     <= {bit_s, R[N-1:1]};
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    c_reg <= bit_c;
                    cnt   <= cnt + 1'b1;
                    // Carry out of bit N-2 is the carry into the MSB.
                    if (cnt == MSB_IN) cmsb_in <= bit_c;
                    // Flags update on the last bit so they are final in DONE.
                    if (cnt == LAST) begin
                        cout <= bit_c;
                        ovf  <= cmsb_in ^ bit_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
module tb_serial_add_sub;

    localparam int N = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         start, sub;
    logic [N-1:0] x, y;
    logic         ready, busy, done;
    logic [N-1:0] r;
    logic         cout, ovf;

    serial_add_sub #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .X     (x),
        .Y     (y),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .R     (r),
        .cout  (cout),
        .ovf   (ovf)
    );

    // ---------------- scoreboard ----------------
    // entry = {R, cout, ovf}
    logic [N+1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int cyc = 0;
    int last_done = -1;
    int busy_run = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference model built from signed/unsigned integer arithmetic.
    function automatic logic [N+1:0] model(input logic s, input logic [N-1:0] a, input logic [N-1:0] b);
        int sa, sb, res, ua, ub;
        logic [N-1:0] rr;
        logic co, ov;
        sa = $signed(a);
        sb = $signed(b);
        ua = int'(a);
        ub = int'(b);
        res = s ? (sa - sb) : (sa + sb);
        rr  = N'(res);
        ov  = (res > (2**(N-1) - 1)) || (res < -(2**(N-1)));
        co  = s ? (ua >= ub) : ((ua + ub) >= 2**N);
        return {rr, co, ov};
    endfunction

    always @(posedge clk) cyc++;

    // Output monitor: result checks, done spacing and busy length.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            else if (busy_run != 0) begin
                check("busy_len", 16'(busy_run), 16'(N));
                busy_run = 0;
            end
            if (done) begin
                done_cnt++;
                if (last_done >= 0)
                    check("done_gap_ok", 16'(cyc - last_done >= N + 2), 16'd1);
                last_done = cyc;
                check("q_nonempty", 16'(exp_q.size() != 0), 16'd1);
                if (exp_q.size() != 0) begin
                    logic [N+1:0] e;
                    e = exp_q.pop_front();
                    check("R",    16'(r),    16'(e[N+1:2]));
                    check("cout", 16'(cout), 16'(e[1]));
                    check("ovf",  16'(ovf),  16'(e[0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Waits for ready, presents one request for a single cycle, returns in RUN cycle 1.
    task automatic issue(input logic s, input logic [N-1:0] a, input logic [N-1:0] b);
        for (int i = 0; i < 20 && !ready; i++) @(negedge clk);
        check("ready_wait", 16'(ready), 16'd1);
        start = 1'b1;
        sub   = s;
        x     = a;
        y     = b;
        exp_q.push_back(model(s, a, b));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && !(ready && exp_q.size() == 0); i++) @(negedge clk);
        check("drain", 16'(exp_q.size()), 16'd0);
    endtask

    // ---------------- directed sequence ----------------
    int idx[512];
    int dref;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        x     = '0;
        y     = '0;
        #2;
        check("rst_ready", 16'(ready), 16'd1);
        check("rst_busy",  16'(busy),  16'd0);
        check("rst_done",  16'(done),  16'd0);
        check("rst_R",     16'(r),     16'd0);
        check("rst_cout",  16'(cout),  16'd0);
        check("rst_ovf",   16'(ovf),   16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 5 - 3 with latency check: done appears in the cycle after edge N.
        issue(1'b1, 4'b0101, 4'b0011);
        repeat (3) @(negedge clk);
        check("lat_done_early", 16'(done), 16'd0);
        check("lat_busy_last",  16'(busy), 16'd1);
        @(negedge clk);
        check("lat_done", 16'(done), 16'd1);
        @(negedge clk);
        check("R_held", 16'(r), 16'b0010);
        check("done_pulse", 16'(done), 16'd0);

        issue(1'b1, 4'b0011, 4'b0101);
        issue(1'b1, 4'b1000, 4'b0001);
        issue(1'b0, 4'b0111, 4'b0001);
        issue(1'b1, 4'b0000, 4'b1000);
        wait_idle();

        // Starts during RUN cycle 2 and DONE are ignored.
        dref = done_cnt;
        issue(1'b0, 4'b0010, 4'b0011);
        @(negedge clk);
        start = 1'b1; sub = 1'b1; x = 4'b1111; y = 4'b0110;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("ign_in_done", 16'(done), 16'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (N + 3) @(negedge clk);
        check("ign_done_once", 16'(done_cnt - dref), 16'd1);
        check("ign_q_empty", 16'(exp_q.size()), 16'd0);

        // Reset during RUN cycle 2 aborts the operation.
        dref = done_cnt;
        issue(1'b1, 4'b0110, 4'b0010);
        @(negedge clk);
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check("abort_ready", 16'(ready), 16'd1);
        check("abort_busy",  16'(busy),  16'd0);
        check("abort_done",  16'(done),  16'd0);
        check("abort_R",     16'(r),     16'd0);
        check("abort_cout",  16'(cout),  16'd0);
        check("abort_ovf",   16'(ovf),   16'd0);
        repeat (N + 2) @(negedge clk);
        check("abort_no_done", 16'(done_cnt - dref), 16'd0);
        rst_n = 1'b1;
        issue(1'b0, 4'b1101, 4'b0110);
        wait_idle();

        // All (sub, X, Y) combinations, shuffled, back-to-back.
        for (int i = 0; i < 512; i++) idx[i] = i;
        for (int i = 511; i > 0; i--) begin
            int j, t;
            j = $urandom_range(i, 0);
            t = idx[i]; idx[i] = idx[j]; idx[j] = t;
        end
        dref = done_cnt;
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(idx[i]);
            issue(v[8], v[7:4], v[3:0]);
        end
        wait_idle();
        check("exh_done_count", 16'(done_cnt - dref), 16'd512);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
